// File: rtl/if_id_stage.sv
// IF/ID pipeline register for the 5-stage RV32I core: captures fetch outputs with
// stall/flush control, pre-splits instruction fields and decodes the immediate.
module if_id_stage #(
  parameter int unsigned              WIDTH     = 32,
  parameter int unsigned              CNT_W     = 16,
  parameter logic [WIDTH-1:0]         NOP_INSTR = 32'h00000013
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             StallD,
  input  logic             FlushD,
  input  logic [WIDTH-1:0] InstrF,
  input  logic [WIDTH-1:0] PCF,
  input  logic [WIDTH-1:0] PCPlus4F,
  output logic [WIDTH-1:0] InstrD,
  output logic [WIDTH-1:0] PCD,
  output logic [WIDTH-1:0] PCPlus4D,
  output logic             ValidD,
  output logic [6:0]       OpD,
  output logic [4:0]       RdD,
  output logic [2:0]       Funct3D,
  output logic [4:0]       Rs1D,
  output logic [4:0]       Rs2D,
  output logic             Funct7b5D,
  output logic [WIDTH-1:0] ImmExtD,
  output logic [CNT_W-1:0] StallCnt,
  output logic [CNT_W-1:0] FlushCnt
);

  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_IMM    = 7'b0010011;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;
  localparam logic [6:0] OP_JAL    = 7'b1101111;

  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  logic [WIDTH-1:0] instr_q;
  logic [WIDTH-1:0] pc_q;
  logic [WIDTH-1:0] pc_plus4_q;
  logic             valid_q;
  logic [CNT_W-1:0] stall_cnt_q;
  logic [CNT_W-1:0] flush_cnt_q;
  logic             sign;

  // Flush outranks stall so a redirect is never lost behind a load-use hold.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      instr_q    <= NOP_INSTR;
      pc_q       <= '0;
      pc_plus4_q <= '0;
      valid_q    <= 1'b0;
    end else if (FlushD) begin
      instr_q    <= NOP_INSTR;
      pc_q       <= '0;
      pc_plus4_q <= '0;
      valid_q    <= 1'b0;
    end else if (!StallD) begin
      instr_q    <= InstrF;
      pc_q       <= PCF;
      pc_plus4_q <= PCPlus4F;
      valid_q    <= 1'b1;
    end
  end

  // Debug event counters stick at all-ones rather than wrapping.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      stall_cnt_q <= '0;
      flush_cnt_q <= '0;
    end else begin
      if (StallD && !FlushD && stall_cnt_q != CNT_MAX)
        stall_cnt_q <= stall_cnt_q + 1'b1;
      if (FlushD && flush_cnt_q != CNT_MAX)
        flush_cnt_q <= flush_cnt_q + 1'b1;
    end
  end

  assign InstrD    = instr_q;
  assign PCD       = pc_q;
  assign PCPlus4D  = pc_plus4_q;
  assign ValidD    = valid_q;
  assign StallCnt  = stall_cnt_q;
  assign FlushCnt  = flush_cnt_q;

  assign OpD       = instr_q[6:0];
  assign RdD       = instr_q[11:7];
  assign Funct3D   = instr_q[14:12];
  assign Rs1D      = instr_q[19:15];
  assign Rs2D      = instr_q[24:20];
  assign Funct7b5D = instr_q[30];
  assign sign      = instr_q[31];

  always_comb begin
    ImmExtD = '0;
    case (OpD)
      OP_LOAD, OP_IMM, OP_JALR:
        ImmExtD = {{(WIDTH-12){sign}}, instr_q[31:20]};
      OP_STORE:
        ImmExtD = {{(WIDTH-12){sign}}, instr_q[31:25], instr_q[11:7]};
      OP_BRANCH:
        ImmExtD = {{(WIDTH-13){sign}}, instr_q[31], instr_q[7], instr_q[30:25],
                   instr_q[11:8], 1'b0};
      OP_LUI, OP_AUIPC:
        ImmExtD = {{(WIDTH-32){sign}}, instr_q[31:12], 12'b0};
      OP_JAL:
        ImmExtD = {{(WIDTH-21){sign}}, instr_q[31], instr_q[19:12], instr_q[20],
                   instr_q[30:21], 1'b0};
      default:
        ImmExtD = '0;
    endcase
  end

endmodule

// File: tb/tb_if_id_stage.sv
// Directed bench for if_id_stage: load, stall, flush priority, immediate formats,
// counter saturation (narrow-counter instance) and asynchronous reset.
module tb_if_id_stage;

  logic        clk = 1'b0;
  logic        rst;
  logic        StallD, FlushD;
  logic [31:0] InstrF, PCF, PCPlus4F;

  logic [31:0] InstrD, PCD, PCPlus4D, ImmExtD;
  logic        ValidD, Funct7b5D;
  logic [6:0]  OpD;
  logic [4:0]  RdD, Rs1D, Rs2D;
  logic [2:0]  Funct3D;
  logic [15:0] StallCnt, FlushCnt;

  logic [31:0] s_InstrD, s_PCD, s_PCPlus4D, s_ImmExtD;
  logic        s_ValidD, s_Funct7b5D;
  logic [6:0]  s_OpD;
  logic [4:0]  s_RdD, s_Rs1D, s_Rs2D;
  logic [2:0]  s_Funct3D;
  logic [3:0]  s_StallCnt, s_FlushCnt;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  if_id_stage dut (
    .clk(clk), .rst(rst), .StallD(StallD), .FlushD(FlushD),
    .InstrF(InstrF), .PCF(PCF), .PCPlus4F(PCPlus4F),
    .InstrD(InstrD), .PCD(PCD), .PCPlus4D(PCPlus4D), .ValidD(ValidD),
    .OpD(OpD), .RdD(RdD), .Funct3D(Funct3D), .Rs1D(Rs1D), .Rs2D(Rs2D),
    .Funct7b5D(Funct7b5D), .ImmExtD(ImmExtD),
    .StallCnt(StallCnt), .FlushCnt(FlushCnt)
  );

  if_id_stage #(.CNT_W(4)) dut_sat (
    .clk(clk), .rst(rst), .StallD(StallD), .FlushD(FlushD),
    .InstrF(InstrF), .PCF(PCF), .PCPlus4F(PCPlus4F),
    .InstrD(s_InstrD), .PCD(s_PCD), .PCPlus4D(s_PCPlus4D), .ValidD(s_ValidD),
    .OpD(s_OpD), .RdD(s_RdD), .Funct3D(s_Funct3D), .Rs1D(s_Rs1D), .Rs2D(s_Rs2D),
    .Funct7b5D(s_Funct7b5D), .ImmExtD(s_ImmExtD),
    .StallCnt(s_StallCnt), .FlushCnt(s_FlushCnt)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic load(input logic [31:0] instr, input logic [31:0] pc);
    InstrF   = instr;
    PCF      = pc;
    PCPlus4F = pc + 32'd4;
    tick();
  endtask

  initial begin
    rst = 1'b1; StallD = 1'b0; FlushD = 1'b0;
    InstrF = '0; PCF = '0; PCPlus4F = '0;
    #2;
    check("rst_instr", InstrD, 32'h00000013);
    check("rst_valid", {31'b0, ValidD}, 32'd0);
    check("rst_pc", PCD, 32'd0);
    check("rst_pc4", PCPlus4D, 32'd0);
    check("rst_op", {25'b0, OpD}, 32'h13);
    check("rst_imm", ImmExtD, 32'd0);
    check("rst_stallcnt", {16'b0, StallCnt}, 32'd0);
    check("rst_flushcnt", {16'b0, FlushCnt}, 32'd0);

    tick(); tick();
    rst = 1'b0;

    // addi x1,x0,5
    load(32'h00500093, 32'h0);
    check("ld_instr", InstrD, 32'h00500093);
    check("ld_valid", {31'b0, ValidD}, 32'd1);
    check("ld_rd", {27'b0, RdD}, 32'd1);
    check("ld_rs1", {27'b0, Rs1D}, 32'd0);
    check("ld_imm", ImmExtD, 32'd5);
    check("ld_pc4", PCPlus4D, 32'd4);

    // addi x2,x2,-4
    load(32'hFFC10113, 32'h10);
    check("neg_imm", ImmExtD, 32'hFFFFFFFC);
    check("neg_rd", {27'b0, RdD}, 32'd2);
    check("neg_rs1", {27'b0, Rs1D}, 32'd2);
    check("neg_pc", PCD, 32'h10);

    StallD = 1'b1;
    for (int i = 0; i < 3; i++) begin
      InstrF = 32'h00A00513 + 32'(i);
      PCF    = 32'h14 + 32'(4 * i);
      tick();
      check("stall_instr", InstrD, 32'hFFC10113);
      check("stall_imm", ImmExtD, 32'hFFFFFFFC);
      check("stall_pc", PCD, 32'h10);
      check("stall_valid", {31'b0, ValidD}, 32'd1);
    end
    check("stallcnt_3", {16'b0, StallCnt}, 32'd3);
    check("flushcnt_0", {16'b0, FlushCnt}, 32'd0);

    FlushD = 1'b1;
    tick();
    check("flush_instr", InstrD, 32'h00000013);
    check("flush_valid", {31'b0, ValidD}, 32'd0);
    check("flush_pc", PCD, 32'd0);
    check("flush_pc4", PCPlus4D, 32'd0);
    check("flush_flushcnt", {16'b0, FlushCnt}, 32'd1);
    check("flush_stallcnt", {16'b0, StallCnt}, 32'd3);
    StallD = 1'b0; FlushD = 1'b0;

    load(32'hFE112E23, 32'h40);
    check("sw_imm", ImmExtD, 32'hFFFFFFFC);
    check("sw_f7b5", {31'b0, Funct7b5D}, 32'd1);
    check("sw_rs2", {27'b0, Rs2D}, 32'd1);
    load(32'hFE000EE3, 32'h44);
    check("beq_imm", ImmExtD, 32'hFFFFFFFC);
    load(32'h123450B7, 32'h48);
    check("lui_imm", ImmExtD, 32'h12345000);
    check("lui_op", {25'b0, OpD}, 32'h37);
    load(32'h0080006F, 32'h4C);
    check("jal_imm", ImmExtD, 32'h00000008);
    // add x3,x1,x2: R-type carries no immediate
    load(32'h002081B3, 32'h50);
    check("add_imm", ImmExtD, 32'd0);
    check("add_rd", {27'b0, RdD}, 32'd3);
    check("add_rs2", {27'b0, Rs2D}, 32'd2);
    check("add_funct3", {29'b0, Funct3D}, 32'd0);

    // A stall after a flush keeps the bubble a bubble.
    FlushD = 1'b1;
    tick();
    FlushD = 1'b0; StallD = 1'b1; InstrF = 32'h00100093;
    tick();
    check("bubble_hold_valid", {31'b0, ValidD}, 32'd0);
    check("bubble_hold_instr", InstrD, 32'h00000013);
    check("flushcnt_2", {16'b0, FlushCnt}, 32'd2);
    check("stallcnt_4", {16'b0, StallCnt}, 32'd4);

    for (int i = 0; i < 10; i++) tick();
    check("sat_cnt_14", {28'b0, s_StallCnt}, 32'd14);
    for (int i = 0; i < 10; i++) tick();
    check("sat_cnt_15", {28'b0, s_StallCnt}, 32'd15);
    check("wide_cnt_24", {16'b0, StallCnt}, 32'd24);
    check("sat_flushcnt", {28'b0, s_FlushCnt}, 32'd2);
    StallD = 1'b0;

    load(32'h00500093, 32'h60);
    check("pre_arst_valid", {31'b0, ValidD}, 32'd1);
    #3;
    rst = 1'b1;
    #1;
    check("arst_valid", {31'b0, ValidD}, 32'd0);
    check("arst_instr", InstrD, 32'h00000013);
    check("arst_pc", PCD, 32'd0);
    check("arst_stallcnt", {16'b0, StallCnt}, 32'd0);
    check("arst_flushcnt", {16'b0, FlushCnt}, 32'd0);
    #2;
    rst = 1'b0;
    load(32'h123450B7, 32'h70);
    check("post_rst_valid", {31'b0, ValidD}, 32'd1);
    check("post_rst_pc", PCD, 32'h70);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
